// File: rtl/dwbuart_pkg.sv
// rtl/dwbuart_pkg.sv - shared receive entry type, frame width and entry builder
package dwbuart_pkg;

   localparam int FRAME_W = 11;

   typedef struct packed {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       brk;
   } rx_entry_t;

   // Turn a front-end frame plus its error strobes into a queue entry
   function automatic rx_entry_t build_entry(
      input logic [FRAME_W-1:0] frame,
      input logic               ds,
      input logic [1:0]         par_cfg,
      input logic               pe_in,
      input logic               fe_in
   );
      rx_entry_t e;
      logic      par_en;
      logic      par_bit;
      par_en  = |par_cfg;
      par_bit = ds ? frame[8] : frame[7];
      e.data  = ds ? frame[7:0] : {1'b0, frame[6:0]};
      e.pe    = pe_in & par_en;
      e.fe    = fe_in;
      // A break is a framing error on an all-zero character including the parity slot
      e.brk   = fe_in & (e.data == 8'h00) & (~par_bit | ~par_en);
      return e;
   endfunction

endpackage

// File: rtl/rx_backend_if.sv
// rtl/rx_backend_if.sv - receive queue head / pop handshake bundle
interface rx_backend_if;
   logic [7:0] rx_data_o;
   logic       rx_pe_o;
   logic       rx_fe_o;
   logic       rx_brk_o;
   logic       rx_valid_o;
   logic       rx_ready_i;

   modport master (
      output rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o,
      input  rx_ready_i
   );

   modport slave (
      input  rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o,
      output rx_ready_i
   );
endinterface

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous first-word-fall-through queue of rx_entry_t
module rx_fifo
   import dwbuart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  rx_entry_t                push_data,
   input  logic                     pop,
   output rx_entry_t                head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rx_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;
   logic            do_push;
   logic            do_pop;

   // A single-entry queue has only the wrap bit, so its address is always zero
   generate
      if (DEPTH > 1) begin : g_addr
         assign wr_addr = wr_ptr[AW-1:0];
         assign rd_addr = rd_ptr[AW-1:0];
      end else begin : g_addr_single
         assign wr_addr = '0;
         assign rd_addr = '0;
      end
   endgenerate

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_addr == rd_addr);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_addr];

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_addr] <= push_data;
      end
   end

   // Pointer update with extra wrap bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rx_backend.sv
// rtl/rx_backend.sv - UART receive back-end: capture, entry build, queue, overrun (DWBUART_RX_FIFO_EN selects DEPTH-entry queue, else one holding register)
module rx_backend
   import dwbuart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cr_ds_i,
   input  logic [1:0]               cr_p_i,
   input  logic [FRAME_W-1:0]       frame_i,
   input  logic                     parity_err_i,
   input  logic                     frame_err_i,
   input  logic                     frame_valid_i,
   rx_backend_if.master             rx_if,
   output logic [$clog2(DEPTH):0]   rx_level_o,
   output logic                     rx_full_o,
   output logic                     overrun_o,
   input  logic                     clear_overrun_i
);

`ifdef DWBUART_RX_FIFO_EN
   localparam int FIFO_DEPTH = DEPTH;
`else
   localparam int FIFO_DEPTH = 1;
`endif
   localparam int FLW = $clog2(FIFO_DEPTH) + 1;

   logic                fv_q;
   logic                cap_q;
   rx_entry_t           entry_q;
   logic                rise;
   logic                pop;
   logic                push;
   logic                drop;
   rx_entry_t           head;
   logic [FLW-1:0]      fifo_level;
   logic                fifo_full;
   logic                fifo_empty;

   assign rise = frame_valid_i & ~fv_q;

   // Edge detect; entry is built here so configuration is sampled at capture time
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fv_q    <= 1'b0;
         cap_q   <= 1'b0;
         entry_q <= '0;
      end else begin
         fv_q  <= frame_valid_i;
         cap_q <= rise;
         if (rise) begin
            entry_q <= build_entry(frame_i, cr_ds_i, cr_p_i, parity_err_i, frame_err_i);
         end
      end
   end

   assign pop  = rx_if.rx_ready_i & ~fifo_empty;
   assign push = cap_q & (~fifo_full | pop);
   assign drop = cap_q & fifo_full & ~pop;

   rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .push_data (entry_q),
      .pop       (pop),
      .head      (head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sticky overrun; a new drop outranks a same-cycle clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overrun_o <= 1'b0;
      end else if (drop) begin
         overrun_o <= 1'b1;
      end else if (clear_overrun_i) begin
         overrun_o <= 1'b0;
      end
   end

   // Head outputs read zero while the queue is empty; level zero-extended
   always_comb begin
      rx_if.rx_data_o  = 8'h00;
      rx_if.rx_pe_o    = 1'b0;
      rx_if.rx_fe_o    = 1'b0;
      rx_if.rx_brk_o   = 1'b0;
      rx_level_o       = '0;
      rx_level_o[FLW-1:0] = fifo_level;
      if (!fifo_empty) begin
         rx_if.rx_data_o = head.data;
         rx_if.rx_pe_o   = head.pe;
         rx_if.rx_fe_o   = head.fe;
         rx_if.rx_brk_o  = head.brk;
      end
   end

   assign rx_if.rx_valid_o = ~fifo_empty;
   assign rx_full_o        = fifo_full;

endmodule

// File: tb/tb_rx_backend.sv
// tb/tb_rx_backend.sv - scoreboard bench for rx_backend (adapts to DWBUART_RX_FIFO_EN)
module tb_rx_backend;
   import dwbuart_pkg::*;

   localparam int DEPTH = 8;
`ifdef DWBUART_RX_FIFO_EN
   localparam int EFF = DEPTH;
`else
   localparam int EFF = 1;
`endif
   localparam int LW = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cr_ds_i;
   logic [1:0]    cr_p_i;
   logic [10:0]   frame_i;
   logic          parity_err_i;
   logic          frame_err_i;
   logic          frame_valid_i;
   logic [LW-1:0] rx_level_o;
   logic          rx_full_o;
   logic          overrun_o;
   logic          clear_overrun_i;

   rx_backend_if rx_if ();

   rx_backend #(.DEPTH(DEPTH)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .cr_ds_i         (cr_ds_i),
      .cr_p_i          (cr_p_i),
      .frame_i         (frame_i),
      .parity_err_i    (parity_err_i),
      .frame_err_i     (frame_err_i),
      .frame_valid_i   (frame_valid_i),
      .rx_if           (rx_if),
      .rx_level_o      (rx_level_o),
      .rx_full_o       (rx_full_o),
      .overrun_o       (overrun_o),
      .clear_overrun_i (clear_overrun_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   rx_entry_t sb[$];
   int mlevel = 0;

   function automatic rx_entry_t model(input logic [10:0] f, input logic ds, input logic [1:0] p,
                                       input logic pe, input logic fe);
      rx_entry_t e;
      logic [7:0] d;
      d = f[7:0];
      if (!ds) d[7] = 1'b0;
      e.data = d;
      e.pe   = pe && (p != 2'b00);
      e.fe   = fe;
      if (!fe || d != 8'h00) e.brk = 1'b0;
      else if (p == 2'b00)   e.brk = 1'b1;
      else                   e.brk = ds ? ~f[8] : ~f[7];
      return e;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic put(input logic [10:0] f, input logic ds, input logic [1:0] p,
                      input logic pe, input logic fe);
      cr_ds_i = ds; cr_p_i = p; frame_i = f; parity_err_i = pe; frame_err_i = fe;
      frame_valid_i = 1'b1;
      if (mlevel < EFF) begin
         sb.push_back(model(f, ds, p, pe, fe));
         mlevel++;
      end
      tick;
      frame_valid_i = 1'b0;
      tick;
   endtask

   task automatic test_pop_head;
      rx_entry_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL pop_head: scoreboard empty, rx_valid_o=%0b", rx_if.rx_valid_o);
      end else begin
         e = sb.pop_front();
         if ({rx_if.rx_valid_o, rx_if.rx_data_o, rx_if.rx_pe_o, rx_if.rx_fe_o, rx_if.rx_brk_o} !== {1'b1, e}) begin
            failures++;
            $display("FAIL pop_head: got v/data/pe/fe/brk=%0b/%02h/%0b/%0b/%0b expected 1/%02h/%0b/%0b/%0b",
                     rx_if.rx_valid_o, rx_if.rx_data_o, rx_if.rx_pe_o, rx_if.rx_fe_o, rx_if.rx_brk_o,
                     e.data, e.pe, e.fe, e.brk);
         end
      end
      rx_if.rx_ready_i = 1'b1;
      tick;
      rx_if.rx_ready_i = 1'b0;
      if (mlevel > 0) mlevel--;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; cr_ds_i = 1'b1; cr_p_i = 2'b00; frame_i = '0; parity_err_i = 1'b0;
      frame_err_i = 1'b0; frame_valid_i = 1'b0; clear_overrun_i = 1'b0; rx_if.rx_ready_i = 1'b0;
      tick; tick;
      checks++;
      if ({rx_if.rx_data_o, rx_if.rx_pe_o, rx_if.rx_fe_o, rx_if.rx_brk_o} !== 11'h0) begin
         failures++; $display("FAIL reset_head: got %03h expected 000",
                              {rx_if.rx_data_o, rx_if.rx_pe_o, rx_if.rx_fe_o, rx_if.rx_brk_o});
      end
      checks++;
      if (rx_if.rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", rx_if.rx_valid_o); end
      checks++;
      if (rx_level_o !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", rx_level_o); end
      checks++;
      if (rx_full_o !== 1'b0) begin failures++; $display("FAIL reset_full: got %0b expected 0", rx_full_o); end
      checks++;
      if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun_o); end
      rst_ni = 1'b1;
      tick;
   endtask

   task automatic test_8n1;
      cr_ds_i = 1'b1; cr_p_i = 2'b00; frame_i = 11'h4A5; parity_err_i = 1'b0; frame_err_i = 1'b0;
      frame_valid_i = 1'b1;
      sb.push_back(model(11'h4A5, 1'b1, 2'b00, 1'b0, 1'b0));
      mlevel++;
      tick;
      frame_valid_i = 1'b0;
      checks++;
      if (rx_if.rx_valid_o !== 1'b0) begin failures++; $display("FAIL 8n1_early_valid: got %0b expected 0", rx_if.rx_valid_o); end
      tick;
      checks++;
      if (rx_if.rx_valid_o !== 1'b1 || rx_level_o !== LW'(1)) begin
         failures++; $display("FAIL 8n1_latency: valid=%0b level=%0d expected 1/1", rx_if.rx_valid_o, rx_level_o);
      end
      checks++;
      if (rx_if.rx_data_o !== 8'hA5) begin failures++; $display("FAIL 8n1_data: got %02h expected a5", rx_if.rx_data_o); end
      tick;
      test_pop_head;
      checks++;
      if (rx_if.rx_valid_o !== 1'b0 || rx_if.rx_data_o !== 8'h00) begin
         failures++; $display("FAIL 8n1_after_pop: valid=%0b data=%02h expected 0/00", rx_if.rx_valid_o, rx_if.rx_data_o);
      end
   endtask

   task automatic test_7bit_parity;
      put(11'h0FF, 1'b0, 2'b00, 1'b1, 1'b0);
      checks++;
      if (rx_if.rx_data_o !== 8'h7F || rx_if.rx_pe_o !== 1'b0) begin
         failures++; $display("FAIL 7bit_nopar: data=%02h pe=%0b expected 7f/0", rx_if.rx_data_o, rx_if.rx_pe_o);
      end
      cr_ds_i = 1'b1; cr_p_i = 2'b01;
      tick;
      checks++;
      if (rx_if.rx_data_o !== 8'h7F || rx_if.rx_pe_o !== 1'b0) begin
         failures++; $display("FAIL cfg_change_stored: data=%02h pe=%0b expected 7f/0", rx_if.rx_data_o, rx_if.rx_pe_o);
      end
      test_pop_head;
      put(11'h0FF, 1'b0, 2'b01, 1'b1, 1'b0);
      checks++;
      if (rx_if.rx_pe_o !== 1'b1) begin failures++; $display("FAIL 7bit_par_pe: got %0b expected 1", rx_if.rx_pe_o); end
      test_pop_head;
   endtask

   task automatic test_break;
      put(11'h000, 1'b1, 2'b00, 1'b0, 1'b1);
      checks++;
      if ({rx_if.rx_data_o, rx_if.rx_fe_o, rx_if.rx_brk_o} !== {8'h00, 1'b1, 1'b1}) begin
         failures++; $display("FAIL break_flags: data=%02h fe=%0b brk=%0b expected 00/1/1",
                              rx_if.rx_data_o, rx_if.rx_fe_o, rx_if.rx_brk_o);
      end
      test_pop_head;
      put(11'h100, 1'b1, 2'b01, 1'b0, 1'b1);
      test_pop_head;
      put(11'h080, 1'b0, 2'b10, 1'b0, 1'b1);
      test_pop_head;
   endtask

   task automatic test_overrun;
      for (int i = 0; i <= EFF; i++) begin
         put(11'((i * 37 + 1) & 8'hFF), 1'b1, 2'b00, 1'b0, 1'b0);
      end
      checks++;
      if (rx_level_o !== LW'(EFF) || rx_full_o !== 1'b1 || overrun_o !== 1'b1) begin
         failures++; $display("FAIL overrun_full: level=%0d full=%0b ovr=%0b expected %0d/1/1",
                              rx_level_o, rx_full_o, overrun_o, EFF);
      end
      checks++;
      if (rx_if.rx_data_o !== sb[0].data) begin
         failures++; $display("FAIL overrun_head: got %02h expected %02h", rx_if.rx_data_o, sb[0].data);
      end
      frame_i = 11'h055; frame_valid_i = 1'b1;
      tick;
      frame_valid_i = 1'b0; clear_overrun_i = 1'b1;
      tick;
      clear_overrun_i = 1'b0;
      checks++;
      if (overrun_o !== 1'b1 || rx_level_o !== LW'(EFF)) begin
         failures++; $display("FAIL overrun_set_wins: ovr=%0b level=%0d expected 1/%0d", overrun_o, rx_level_o, EFF);
      end
      clear_overrun_i = 1'b1;
      tick;
      clear_overrun_i = 1'b0;
      checks++;
      if (overrun_o !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %0b expected 0", overrun_o); end
   endtask

   task automatic test_push_pop_full;
      cr_ds_i = 1'b1; cr_p_i = 2'b00; parity_err_i = 1'b0; frame_err_i = 1'b0;
      frame_i = 11'h0C3; frame_valid_i = 1'b1;
      tick;
      frame_valid_i = 1'b0;
      test_pop_head;
      sb.push_back(model(11'h0C3, 1'b1, 2'b00, 1'b0, 1'b0));
      mlevel++;
      checks++;
      if (rx_level_o !== LW'(EFF) || overrun_o !== 1'b0 || rx_full_o !== 1'b1) begin
         failures++; $display("FAIL push_pop_full: level=%0d ovr=%0b full=%0b expected %0d/0/1",
                              rx_level_o, overrun_o, rx_full_o, EFF);
      end
      for (int i = 0; i < EFF; i++) test_pop_head;
      checks++;
      if (rx_if.rx_valid_o !== 1'b0 || rx_level_o !== '0) begin
         failures++; $display("FAIL drain_empty: valid=%0b level=%0d expected 0/0", rx_if.rx_valid_o, rx_level_o);
      end
   endtask

   task automatic test_long_strobe;
      cr_ds_i = 1'b1; cr_p_i = 2'b00; frame_i = 11'h03C; frame_valid_i = 1'b1;
      sb.push_back(model(11'h03C, 1'b1, 2'b00, 1'b0, 1'b0));
      mlevel++;
      tick; tick; tick;
      frame_valid_i = 1'b0;
      tick; tick; tick;
      checks++;
      if (rx_level_o !== LW'(1)) begin failures++; $display("FAIL long_strobe_level: got %0d expected 1", rx_level_o); end
      test_pop_head;
      checks++;
      if (rx_if.rx_valid_o !== 1'b0) begin failures++; $display("FAIL long_strobe_extra: valid=%0b expected 0", rx_if.rx_valid_o); end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 5; i++) put(11'(8'h10 + i), 1'b1, 2'b00, 1'b0, 1'b1);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({rx_if.rx_data_o, rx_if.rx_pe_o, rx_if.rx_fe_o, rx_if.rx_brk_o, rx_if.rx_valid_o,
           rx_level_o, rx_full_o, overrun_o} !== '0) begin
         failures++; $display("FAIL async_reset: data=%02h fe=%0b valid=%0b level=%0d full=%0b ovr=%0b expected all 0",
                              rx_if.rx_data_o, rx_if.rx_fe_o, rx_if.rx_valid_o, rx_level_o, rx_full_o, overrun_o);
      end
      sb.delete();
      mlevel = 0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      tick;
      checks++;
      if (rx_if.rx_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %0b expected 0", rx_if.rx_valid_o); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_8n1;
      test_7bit_parity;
      test_break;
      test_overrun;
      test_push_pop_full;
      test_long_strobe;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_backend.md
# rx_backend

Receive back-end of the DWBUART. It consumes aligned frames from the receive front-end, extracts the data byte and the per-frame error flags, and buffers them in a first-word-fall-through queue. The queue is drained by the register/Wishbone layer through a valid/ready pop interface. The block also maintains the RX level, the full/empty status and a sticky overrun flag.

## Interface
Parameters:
- DEPTH, 8: queue depth in entries; power of two, minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- cr_ds_i  in  1  data size: 0 = 7 data bits, 1 = 8 data bits.
- cr_p_i  in  2  parity configuration; nonzero means parity is enabled.
- frame_i  in  11  aligned frame from the front-end: bit0 = first data bit, then parity (if enabled), then stop bit(s).
- parity_err_i  in  1  parity error for the current frame.
- frame_err_i  in  1  stop-bit error for the current frame.
- frame_valid_i  in  1  front-end frame-complete strobe.
- rx_data_o  out  8  data at the queue head.
- rx_pe_o  out  1  parity error flag of the head entry.
- rx_fe_o  out  1  frame error flag of the head entry.
- rx_brk_o  out  1  break flag of the head entry.
- rx_valid_o  out  1  queue is not empty.
- rx_ready_i  in  1  pop request; a pop occurs when rx_valid_o and rx_ready_i are both high.
- rx_level_o  out  $clog2(DEPTH)+1  number of stored entries.
- rx_full_o  out  1  level equals DEPTH.
- overrun_o  out  1  sticky overrun flag.
- clear_overrun_i  in  1  one-cycle clear for overrun_o.

## Operation
Capture:
- A frame is captured on the rising edge of frame_valid_i, detected against a registered copy of frame_valid_i.
- A strobe held high for several cycles counts as a single frame.

Entry construction:
- data = frame_i[7:0] when cr_ds_i = 1.
- data = {1'b0, frame_i[6:0]} when cr_ds_i = 0.
- pe = parity_err_i AND (cr_p_i != 0).
- fe = frame_err_i.
- brk = fe AND all data bits zero AND (parity bit zero, or parity disabled). The parity bit is frame_i[8] when cr_ds_i = 1, otherwise frame_i[7].

Queue behaviour:
- Push when a capture occurs and the queue is not full, or when a capture occurs while full and a pop happens in the same cycle.
- A capture while full with no simultaneous pop drops the new frame, keeps the queue contents unchanged and sets overrun_o.
- Pop advances the read pointer. A pop request while empty is ignored.
- Simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo DEPTH, using an extra wrap bit to distinguish full from empty.

Overrun flag:
- clear_overrun_i clears overrun_o.
- If a new overrun occurs in the same cycle as the clear, the set wins.

Other rules:
- Configuration inputs are sampled at capture time. Changing them does not alter stored entries.
- Head outputs are zero when the queue is empty.

## Timing
- Reset values: rx_data_o = 0, rx_pe_o = rx_fe_o = rx_brk_o = 0, rx_valid_o = 0, rx_level_o = 0, rx_full_o = 0, overrun_o = 0. Pointers and the edge-detect register are cleared.
- Reset is asynchronous. Asserting it mid-operation discards all entries immediately.
- Capture latency: frame_valid_i rising in cycle N gives rx_valid_o = 1 in cycle N+2 and rx_level_o incremented in cycle N+2. This is one cycle for edge detection and one cycle for the write.
- Pop: rx_valid_o AND rx_ready_i in cycle M gives the next head entry (or rx_valid_o = 0) in cycle M+1. Head outputs are combinational reads of the queue storage at the read pointer (FWFT).
- overrun_o rises in the cycle after the dropped push. It falls in the cycle after clear_overrun_i.

## Configuration
- DWBUART_RX_FIFO_EN defined: storage is DEPTH entries, as described above.
- DWBUART_RX_FIFO_EN undefined: DEPTH is ignored and storage is a single holding register.
  - rx_level_o keeps its width but only takes the values 0 or 1.
  - rx_full_o = rx_valid_o.
  - Overrun, push-with-pop-while-full and all latency rules are unchanged.

## Structure
- Package dwbuart_pkg holds:
  - the typedef rx_entry_t, a packed struct {data[7:0], pe, fe, brk};
  - the constant FRAME_W = 11.
- Sub-module rx_fifo: a generic synchronous FWFT queue of rx_entry_t with push, pop, level, full and empty.
  - It is instantiated with DEPTH, or with depth 1 when the macro is undefined.
- rx_backend itself contains the edge detect, entry construction and overrun logic.

## Test plan
- 8N1 configuration (cr_ds_i = 1, cr_p_i = 0), frame_i = 0x4A5 with strobe in cycle 10:
  - rx_valid_o = 1 in cycle 12;
  - rx_data_o = 0xA5, rx_pe_o = 0, rx_fe_o = 0;
  - a pop in cycle 13 gives rx_valid_o = 0 in cycle 14.
- 7-bit data (cr_ds_i = 0), frame_i = 0x0FF → rx_data_o = 0x7F. With parity_err_i = 1 and cr_p_i = 0 → rx_pe_o = 0; with cr_p_i = 2'b01 → rx_pe_o = 1.
- 8 data bits (cr_ds_i = 1), parity disabled (cr_p_i = 0), frame_i = 0x000 with frame_err_i = 1 → rx_fe_o = 1, rx_brk_o = 1, rx_data_o = 0x00.
- DEPTH = 8:
  - push 9 frames without popping → rx_level_o = 8, rx_full_o = 1, overrun_o = 1;
  - the head is still the first frame, and 8 pops return frames 1 to 8 in order;
  - clear_overrun_i asserted together with a new overrun → overrun_o stays 1.
- Full queue with a capture and a pop in the same cycle → no overrun, rx_level_o stays 8.
- A 3-cycle frame_valid_i strobe → exactly one push.
- rst_ni asserted with 5 entries stored → all outputs are 0 asynchronously.
